// File: rtl/command_ring_reader_pkg.sv
// Shared definitions for the xHCI Command Ring reader: FSM state encoding,
// TRB field positions and the read-engine status code that signals a
// completed memory read.
package command_ring_reader_pkg;

  typedef enum logic [2:0] {
    CR_IDLE,
    CR_FETCH_REQ,
    CR_FETCH_POP,
    CR_FETCH_LATCH,
    CR_CHECK,
    CR_DISPATCH
  } cr_state_t;

  // Read-engine status codes (mrd_state)
  localparam logic [3:0] RD_IDLE     = 4'd0;
  localparam logic [3:0] RD_COMPLETE = 4'd4;

  // TRB layout: control dword occupies bits [127:96]
  localparam logic [5:0] TRB_TYPE_LINK = 6'd6;
  localparam int         TRB_CYCLE_BIT = 96;
  localparam int         TRB_TC_BIT    = 97;
  localparam logic [31:0] TRB_BYTES    = 32'h10;

  function automatic logic is_link_trb(input logic [127:0] trb);
    return trb[111:106] == TRB_TYPE_LINK;
  endfunction

endpackage

// File: rtl/command_ring_reader.sv
// command_ring_reader: consumer side of the xHCI Command Ring.
// Fetches one 16-byte TRB at a time from host memory at deq_ptr, stops when
// the cycle bit no longer matches ccs (ring empty), follows Link TRBs
// (optionally toggling ccs) and hands each command TRB to the handler over
// a valid/ready handshake.
// Ports:
//   clk_pcie, rst          clock, synchronous active-high reset
//   run, doorbell          USBCMD.R/S level, doorbell 0 pulse
//   crcr_*                 host CRCR write (pointer, RCS, CS, CA)
//   crr, deq_ptr, ccs      ring running flag, dequeue pointer, cycle state
//   mrd_*                  memory read engine request / status / data
//   trb_valid/data/addr    TRB to command handler, trb_ready accepts it
//   stopped, stopped_ptr   pulse: emit Command Ring Stopped event
//   link_err               pulse: too many consecutive Link TRBs
module command_ring_reader
  import command_ring_reader_pkg::*;
#(
  parameter int LINK_LIMIT = 8
) (
  input  logic         clk_pcie,
  input  logic         rst,
  input  logic         run,
  input  logic         doorbell,
  input  logic         crcr_wr,
  input  logic [57:0]  crcr_ptr,
  input  logic         crcr_rcs,
  input  logic         crcr_cs,
  input  logic         crcr_ca,
  output logic         crr,
  output logic [63:0]  deq_ptr,
  output logic         ccs,
  output logic [63:0]  mrd_addr,
  output logic [31:0]  mrd_length,
  output logic         mrd_has_request,
  output logic         mrd_rd_en,
  input  logic [3:0]   mrd_state,
  input  logic [127:0] mrd_dout,
  output logic         trb_valid,
  output logic [127:0] trb_data,
  output logic [63:0]  trb_addr,
  input  logic         trb_ready,
  output logic         stopped,
  output logic [63:0]  stopped_ptr,
  output logic         link_err
);

  localparam int CNT_W = $clog2(LINK_LIMIT + 1);
  localparam logic [CNT_W-1:0] LINK_LAST = CNT_W'(LINK_LIMIT - 1);

  cr_state_t        state_reg, state_next;
  logic [63:0]      deq_ptr_reg, deq_ptr_next;
  logic             ccs_reg, ccs_next;
  logic             crr_reg, crr_next;
  logic             stop_pend_reg, stop_pend_next;
  logic             db_pend_reg, db_pend_next;
  logic [CNT_W-1:0] link_cnt_reg, link_cnt_next;
  logic [127:0]     trb_reg, trb_next;
  logic             trb_valid_reg, trb_valid_next;
  logic [127:0]     trb_data_reg, trb_data_next;
  logic [63:0]      trb_addr_reg, trb_addr_next;
  logic [63:0]      mrd_addr_reg, mrd_addr_next;
  logic [31:0]      mrd_length_reg, mrd_length_next;
  logic             mrd_has_request_reg, mrd_has_request_next;
  logic             mrd_rd_en_reg, mrd_rd_en_next;
  logic             stopped_reg, stopped_next;
  logic [63:0]      stopped_ptr_reg, stopped_ptr_next;
  logic             link_err_reg, link_err_next;

  logic             stop_req;

  // CS and CA are treated alike: the reader only stops; aborting the
  // command in flight is the handler's job.
  assign stop_req = crcr_wr && (crcr_cs || crcr_ca) && crr_reg;

  always_ff @(posedge clk_pcie) begin
    if (rst) begin
      state_reg           <= CR_IDLE;
      deq_ptr_reg         <= '0;
      ccs_reg             <= 1'b0;
      crr_reg             <= 1'b0;
      stop_pend_reg       <= 1'b0;
      db_pend_reg         <= 1'b0;
      link_cnt_reg        <= '0;
      trb_reg             <= '0;
      trb_valid_reg       <= 1'b0;
      trb_data_reg        <= '0;
      trb_addr_reg        <= '0;
      mrd_addr_reg        <= '0;
      mrd_length_reg      <= '0;
      mrd_has_request_reg <= 1'b0;
      mrd_rd_en_reg       <= 1'b0;
      stopped_reg         <= 1'b0;
      stopped_ptr_reg     <= '0;
      link_err_reg        <= 1'b0;
    end else begin
      state_reg           <= state_next;
      deq_ptr_reg         <= deq_ptr_next;
      ccs_reg             <= ccs_next;
      crr_reg             <= crr_next;
      stop_pend_reg       <= stop_pend_next;
      db_pend_reg         <= db_pend_next;
      link_cnt_reg        <= link_cnt_next;
      trb_reg             <= trb_next;
      trb_valid_reg       <= trb_valid_next;
      trb_data_reg        <= trb_data_next;
      trb_addr_reg        <= trb_addr_next;
      mrd_addr_reg        <= mrd_addr_next;
      mrd_length_reg      <= mrd_length_next;
      mrd_has_request_reg <= mrd_has_request_next;
      mrd_rd_en_reg       <= mrd_rd_en_next;
      stopped_reg         <= stopped_next;
      stopped_ptr_reg     <= stopped_ptr_next;
      link_err_reg        <= link_err_next;
    end
  end

  always_comb begin
    state_next           = state_reg;
    deq_ptr_next         = deq_ptr_reg;
    ccs_next             = ccs_reg;
    crr_next             = crr_reg;
    stop_pend_next       = stop_pend_reg;
    db_pend_next         = db_pend_reg;
    link_cnt_next        = link_cnt_reg;
    trb_next             = trb_reg;
    trb_valid_next       = trb_valid_reg;
    trb_data_next        = trb_data_reg;
    trb_addr_next        = trb_addr_reg;
    mrd_addr_next        = mrd_addr_reg;
    mrd_length_next      = mrd_length_reg;
    mrd_has_request_next = mrd_has_request_reg;
    mrd_rd_en_next       = mrd_rd_en_reg;
    stopped_next         = 1'b0;
    stopped_ptr_next     = stopped_ptr_reg;
    link_err_next        = 1'b0;

    if (stop_req) begin
      stop_pend_next = 1'b1;
    end
    if (doorbell && (state_reg != CR_IDLE)) begin
      db_pend_next = 1'b1;
    end

    case (state_reg)
      CR_IDLE: begin
        if (crcr_wr && !crr_reg) begin
          deq_ptr_next = {crcr_ptr, 6'h0};
          ccs_next     = crcr_rcs;
        end
        // A stop written in the same cycle as a doorbell wins.
        if (stop_pend_reg || stop_req) begin
          stopped_next     = 1'b1;
          stopped_ptr_next = deq_ptr_reg;
          crr_next         = 1'b0;
          stop_pend_next   = 1'b0;
        end else if (crr_reg && !run) begin
          crr_next = 1'b0;
        end else if (doorbell && run) begin
          crr_next   = 1'b1;
          state_next = CR_FETCH_REQ;
        end
      end

      CR_FETCH_REQ: begin
        mrd_addr_next        = deq_ptr_reg;
        mrd_length_next      = TRB_BYTES;
        mrd_has_request_next = 1'b1;
        if (mrd_state == RD_COMPLETE) begin
          mrd_rd_en_next = 1'b1;
          state_next     = CR_FETCH_POP;
        end
      end

      // The read engine presents data one cycle after the pop request.
      CR_FETCH_POP: begin
        state_next = CR_FETCH_LATCH;
      end

      CR_FETCH_LATCH: begin
        trb_next             = mrd_dout;
        mrd_addr_next        = '0;
        mrd_length_next      = '0;
        mrd_has_request_next = 1'b0;
        mrd_rd_en_next       = 1'b0;
        state_next           = CR_CHECK;
      end

      CR_CHECK: begin
        if (trb_reg[TRB_CYCLE_BIT] != ccs_reg) begin
          // Ring empty. A doorbell that arrived while fetching may mean
          // software produced this very TRB meanwhile: look once more.
          if (db_pend_reg || doorbell) begin
            state_next = CR_FETCH_REQ;
          end else begin
            state_next = CR_IDLE;
          end
          db_pend_next = 1'b0;
        end else if (is_link_trb(trb_reg)) begin
          if (link_cnt_reg == LINK_LAST) begin
            link_err_next  = 1'b1;
            crr_next       = 1'b0;
            link_cnt_next  = '0;
            stop_pend_next = 1'b0;
            db_pend_next   = 1'b0;
            state_next     = CR_IDLE;
          end else begin
            deq_ptr_next = {trb_reg[63:4], 4'h0};
            if (trb_reg[TRB_TC_BIT]) begin
              ccs_next = ~ccs_reg;
            end
            link_cnt_next = link_cnt_reg + CNT_W'(1);
            state_next    = CR_FETCH_REQ;
          end
        end else begin
          trb_valid_next = 1'b1;
          trb_data_next  = trb_reg;
          trb_addr_next  = deq_ptr_reg;
          link_cnt_next  = '0;
          state_next     = CR_DISPATCH;
        end
      end

      CR_DISPATCH: begin
        if (trb_ready) begin
          trb_valid_next = 1'b0;
          deq_ptr_next   = deq_ptr_reg + 64'h10;
          if (stop_pend_reg || stop_req) begin
            stopped_next     = 1'b1;
            stopped_ptr_next = deq_ptr_reg + 64'h10;
            crr_next         = 1'b0;
            stop_pend_next   = 1'b0;
            db_pend_next     = 1'b0;
            state_next       = CR_IDLE;
          end else if (!run) begin
            crr_next     = 1'b0;
            db_pend_next = 1'b0;
            state_next   = CR_IDLE;
          end else begin
            state_next = CR_FETCH_REQ;
          end
        end
      end

      default: begin
        state_next = CR_IDLE;
      end
    endcase
  end

  assign crr             = crr_reg;
  assign deq_ptr         = deq_ptr_reg;
  assign ccs             = ccs_reg;
  assign mrd_addr        = mrd_addr_reg;
  assign mrd_length      = mrd_length_reg;
  assign mrd_has_request = mrd_has_request_reg;
  assign mrd_rd_en       = mrd_rd_en_reg;
  assign trb_valid       = trb_valid_reg;
  assign trb_data        = trb_data_reg;
  assign trb_addr        = trb_addr_reg;
  assign stopped         = stopped_reg;
  assign stopped_ptr     = stopped_ptr_reg;
  assign link_err        = link_err_reg;

endmodule
